render_queue: RTL and testbench
===============================

RENDER_QUEUE -- requirements
Module: render_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 25: instruction slots in the queue.
REQ-002 SHALL have parameter CNT_W, default 5: counter width; 2**CNT_W > DEPTH.
REQ-003 SHALL have clk50  in  1: sole clock; all logic on rising edge.
REQ-004 SHALL have reset_n  in  1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have chipselect  in  1: Avalon-MM slave select.
REQ-006 SHALL have write  in  1: Avalon write strobe, qualified by chipselect.
REQ-007 SHALL have read  in  1: Avalon read strobe, qualified by chipselect.
REQ-008 SHALL have address  in  2: word register select.
REQ-009 SHALL have writedata  in  16: Avalon write data.
REQ-010 SHALL have readdata  out  16: Avalon read data, registered.
REQ-011 SHALL have render_queue_dout  out  48: head instruction {magic[47:40], x[39:24], y[23:8], flags[7:0]}.
REQ-012 SHALL have render_queue_pop_front  in  1: consumer removes head on this edge.
REQ-013 SHALL have render_queue_empty  out  1: high when count == 0.

Function
REQ-014 SHALL hold a 48-bit staging register; write to address 0/1/2 loads staging[47:32]/[31:16]/[15:0].
REQ-015 SHALL, on write to address 2, also push {staging[47:16], writedata} into the queue tail in the same cycle (push = commit).
REQ-016 SHALL, on write to address 3, clear the sticky overflow flag; writedata ignored; no push.
REQ-017 SHALL update readdata one cycle after chipselect&read: addr0-2 -> staging word; addr3 -> {overflow, full, empty, 8'b0, count[4:0]} (bit15..0).
REQ-018 SHALL be a circular buffer with head/tail indices wrapping DEPTH-1 -> 0 (not power-of-two wrap).
REQ-019 SHALL present render_queue_dout as memory[head] combinationally from head when count > 0.
REQ-020 SHALL present render_queue_dout = {8'hFF, 40'h0} (do-render marker) when empty, so an idle consumer sees a frame-done instruction.
REQ-021 SHALL on pop with count > 0 advance head, decrement count; pop with count == 0 ignored, no state change.
REQ-022 SHALL on push with count < DEPTH write tail, advance tail, increment count.
REQ-023 SHALL on push with count == DEPTH and no pop drop the instruction and set overflow sticky.
REQ-024 SHALL on simultaneous push and pop with count == DEPTH accept both; count stays DEPTH, no overflow.
REQ-025 SHALL on simultaneous push and pop with count == 0 accept push only; dout shows pushed entry next cycle.
REQ-026 SHALL on simultaneous push and valid pop (0 < count < DEPTH) leave count unchanged, head and tail each advance.
REQ-027 SHALL make pushed data visible on render_queue_dout no earlier than the cycle after the push (1-cycle write latency).
REQ-028 SHALL derive full = (count == DEPTH), empty = (count == 0) from the registered count.

Reset
REQ-029 SHALL on reset_n low at a clock edge clear head, tail, count, staging, overflow and readdata to 0.
REQ-030 SHALL not require clearing queue memory on reset; memory contents are unobservable while empty.
REQ-031 SHALL after reset drive render_queue_empty = 1, render_queue_dout = 48'hFF00_0000_0000.
REQ-032 SHALL on reset mid-burst discard all queued and staged data; first post-reset push lands at index 0.

Verification
REQ-033 Reset, then write addr0=16'h0212, addr1=16'h3400, addr2=16'h5601 -> next cycle dout = 48'h0212_3400_5601, empty = 0, status count = 1.
REQ-034 Pop with one entry -> next cycle empty = 1, dout = 48'hFF00_0000_0000; further pop leaves count = 0.
REQ-035 Push 25 distinct entries, then a 26th -> count = 25, status bit15 = 1, bit14 = 1; 25 pops return entries 1..25 in order, 26th never appears.
REQ-036 With queue full, push and pop same cycle -> count stays 25, overflow stays 0, new entry is last popped.
REQ-037 Push 20, pop 20, push 10, pop 10 -> order preserved across index wrap 24 -> 0; count ends 0.
REQ-038 Push 5, assert reset_n = 0 one cycle mid-sequence -> empty = 1, status reads 16'h2000, next push read back from head.

Source files
------------

// File: rtl/render_queue_if.sv
// Avalon-MM register port plus the consumer-side queue signals of the render queue.
interface render_queue_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [47:0] render_queue_dout;
    logic        render_queue_pop_front;
    logic        render_queue_empty;

    modport master (
        output chipselect, write, read, address, writedata, render_queue_pop_front,
        input  readdata, render_queue_dout, render_queue_empty
    );

    modport slave (
        input  chipselect, write, read, address, writedata, render_queue_pop_front,
        output readdata, render_queue_dout, render_queue_empty
    );
endinterface

// File: rtl/render_queue.sv
// Render instruction queue: a CPU stages 48-bit instructions through three
// 16-bit register writes (the third commits), and a renderer pops them from a
// DEPTH-entry circular buffer. An empty queue presents a frame-done marker.
module render_queue #(
    parameter int DEPTH = 25,
    parameter int CNT_W = 5
) (
    input logic          clk50,
    input logic          reset_n,
    render_queue_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [47:0]      DONE_MARKER = 48'hFF00_0000_0000;

    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [47:0]      staging_q, staging_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      readdata_q, readdata_d;
    logic [47:0]      mem_q [DEPTH];

    logic        wr_en;
    logic        rd_en;
    logic        push;
    logic        pop_ok;
    logic        push_ok;
    logic        full;
    logic        empty;
    logic [47:0] push_data;
    logic [4:0]  count5;

    // Indices wrap at DEPTH-1, not at a power of two.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + CNT_W'(1);
    endfunction

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count5    = 5'(count_q);
    assign wr_en     = bus.chipselect & bus.write;
    assign rd_en     = bus.chipselect & bus.read;
    assign push      = wr_en && (bus.address == 2'd2);
    // The committing write supplies the low word directly, bypassing staging.
    assign push_data = {staging_q[47:16], bus.writedata};
    assign pop_ok    = bus.render_queue_pop_front && !empty;
    // A full queue still accepts a push when the head frees a slot this cycle.
    assign push_ok   = push && (!full || pop_ok);

    // Next-state for staging, queue pointers, overflow flag and register readback.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        staging_d  = staging_q;
        overflow_d = overflow_q;
        readdata_d = readdata_q;

        if (wr_en) begin
            case (bus.address)
                2'd0:    staging_d[47:32] = bus.writedata;
                2'd1:    staging_d[31:16] = bus.writedata;
                2'd2:    staging_d[15:0]  = bus.writedata;
                default: overflow_d       = 1'b0;
            endcase
        end

        if (push && full && !pop_ok) overflow_d = 1'b1;

        if (push_ok) tail_d = wrap_inc(tail_q);
        if (pop_ok)  head_d = wrap_inc(head_q);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rd_en) begin
            case (bus.address)
                2'd0:    readdata_d = staging_q[47:32];
                2'd1:    readdata_d = staging_q[31:16];
                2'd2:    readdata_d = staging_q[15:0];
                default: readdata_d = {overflow_q, full, empty, 8'b0, count5};
            endcase
        end
    end

    // Control and register state with synchronous active-low reset.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            staging_q  <= '0;
            overflow_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            staging_q  <= staging_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    // Queue storage is never cleared; stale slots are hidden while empty.
    always_ff @(posedge clk50) begin
        if (reset_n && push_ok) mem_q[tail_q] <= push_data;
    end

    assign bus.readdata           = readdata_q;
    assign bus.render_queue_dout  = empty ? DONE_MARKER : mem_q[head_q];
    assign bus.render_queue_empty = empty;

endmodule

// File: tb/tb_render_queue.sv
// Directed bench for render_queue: a table of single-cycle register vectors,
// then hand-written sequences for fill/overflow, full push+pop, index wrap,
// steady-state push+pop and mid-stream reset.
`timescale 1ns/1ps
module tb_render_queue;

    localparam logic [47:0] DONE = 48'hFF00_0000_0000;

    logic clk50 = 1'b0;
    logic reset_n;

    render_queue_if rq_if ();

    render_queue #(.DEPTH(25), .CNT_W(5)) dut (
        .clk50   (clk50),
        .reset_n (reset_n),
        .bus     (rq_if.slave)
    );

    always #10 clk50 = ~clk50;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        pop;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic [47:0] exp_dout;
        logic        exp_empty;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic wr, input logic rd, input logic pop,
                                input logic [1:0] addr, input logic [15:0] wdata,
                                input logic chk_rd, input logic [15:0] exp_rd,
                                input logic [47:0] exp_dout, input logic exp_empty);
        vec_t v;
        v.wr = wr; v.rd = rd; v.pop = pop; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_dout = exp_dout; v.exp_empty = exp_empty;
        return v;
    endfunction

    function automatic logic [47:0] ent(input int i);
        logic [15:0] w;
        w = 16'(i);
        return {8'h5A, w, w ^ 16'hBEEF, w[7:0]};
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        rq_if.chipselect             = 1'b0;
        rq_if.write                  = 1'b0;
        rq_if.read                   = 1'b0;
        rq_if.address                = 2'd0;
        rq_if.writedata              = 16'h0;
        rq_if.render_queue_pop_front = 1'b0;
    endtask

    // One bus cycle: drive on the falling edge, return 1 ns after the rising edge.
    task automatic drive(input logic wr, input logic rd, input logic pop,
                         input logic [1:0] addr, input logic [15:0] wd);
        @(negedge clk50);
        rq_if.chipselect             = wr | rd;
        rq_if.write                  = wr;
        rq_if.read                   = rd;
        rq_if.address                = addr;
        rq_if.writedata              = wd;
        rq_if.render_queue_pop_front = pop;
        @(posedge clk50);
        #1;
        idle_bus();
    endtask

    task automatic push48(input logic [47:0] e, input logic with_pop);
        drive(1'b1, 1'b0, 1'b0, 2'd0, e[47:32]);
        drive(1'b1, 1'b0, 1'b0, 2'd1, e[31:16]);
        drive(1'b1, 1'b0, with_pop, 2'd2, e[15:0]);
    endtask

    task automatic pop1();
        drive(1'b0, 1'b0, 1'b1, 2'd0, 16'h0);
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [15:0] v);
        drive(1'b0, 1'b1, 1'b0, addr, 16'h0);
        v = rq_if.readdata;
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset_n = 1'b0;
        @(posedge clk50);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rv;

        tbl[0]  = mk(0, 1, 0, 2'd3, 16'h0000, 1, 16'h2000, DONE, 1);
        tbl[1]  = mk(1, 0, 0, 2'd0, 16'h0212, 0, 16'h0000, DONE, 1);
        tbl[2]  = mk(1, 0, 0, 2'd1, 16'h3400, 0, 16'h0000, DONE, 1);
        tbl[3]  = mk(1, 0, 0, 2'd2, 16'h5601, 0, 16'h0000, 48'h0212_3400_5601, 0);
        tbl[4]  = mk(0, 1, 0, 2'd0, 16'h0000, 1, 16'h0212, 48'h0212_3400_5601, 0);
        tbl[5]  = mk(0, 1, 0, 2'd1, 16'h0000, 1, 16'h3400, 48'h0212_3400_5601, 0);
        tbl[6]  = mk(0, 1, 0, 2'd2, 16'h0000, 1, 16'h5601, 48'h0212_3400_5601, 0);
        tbl[7]  = mk(0, 1, 0, 2'd3, 16'h0000, 1, 16'h0001, 48'h0212_3400_5601, 0);
        tbl[8]  = mk(0, 0, 1, 2'd0, 16'h0000, 0, 16'h0000, DONE, 1);
        tbl[9]  = mk(0, 0, 1, 2'd0, 16'h0000, 0, 16'h0000, DONE, 1);
        tbl[10] = mk(0, 1, 0, 2'd3, 16'h0000, 1, 16'h2000, DONE, 1);
        tbl[11] = mk(1, 0, 0, 2'd3, 16'hFFFF, 0, 16'h0000, DONE, 1);
        tbl[12] = mk(0, 1, 0, 2'd3, 16'h0000, 1, 16'h2000, DONE, 1);

        idle_bus();
        reset_n = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        reset_n = 1'b1;

        check("reset_empty", 48'(rq_if.render_queue_empty), 48'(1'b1));
        check("reset_dout", rq_if.render_queue_dout, DONE);
        check("reset_readdata", 48'(rq_if.readdata), 48'h0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].pop, tbl[i].addr, tbl[i].wdata);
            check($sformatf("vec%0d_dout", i), rq_if.render_queue_dout, tbl[i].exp_dout);
            check($sformatf("vec%0d_empty", i), 48'(rq_if.render_queue_empty), 48'(tbl[i].exp_empty));
            if (tbl[i].chk_rd)
                check($sformatf("vec%0d_readdata", i), 48'(rq_if.readdata), 48'(tbl[i].exp_rd));
        end

        // Fill to capacity, overflow once, then drain in order.
        do_reset();
        for (int i = 1; i <= 25; i++) push48(ent(i), 1'b0);
        push48(ent(26), 1'b0);
        read_reg(2'd3, rv);
        check("fill_overflow_status", 48'(rv), 48'hC019);
        for (int i = 1; i <= 25; i++) begin
            check($sformatf("fill_pop%0d", i), rq_if.render_queue_dout, ent(i));
            pop1();
        end
        check("fill_drained_empty", 48'(rq_if.render_queue_empty), 48'(1'b1));
        check("fill_drained_dout", rq_if.render_queue_dout, DONE);
        read_reg(2'd3, rv);
        check("sticky_overflow_status", 48'(rv), 48'hA000);
        drive(1'b1, 1'b0, 1'b0, 2'd3, 16'h1234);
        read_reg(2'd3, rv);
        check("overflow_cleared_status", 48'(rv), 48'h2000);

        // Push and pop together while full.
        do_reset();
        for (int i = 1; i <= 25; i++) push48(ent(i), 1'b0);
        push48(ent(99), 1'b1);
        read_reg(2'd3, rv);
        check("full_pushpop_status", 48'(rv), 48'h4019);
        for (int i = 2; i <= 25; i++) begin
            check($sformatf("full_pushpop_pop%0d", i), rq_if.render_queue_dout, ent(i));
            pop1();
        end
        check("full_pushpop_last", rq_if.render_queue_dout, ent(99));
        pop1();
        check("full_pushpop_empty", 48'(rq_if.render_queue_empty), 48'(1'b1));

        // Index wrap from 24 back to 0.
        do_reset();
        for (int i = 1; i <= 20; i++) push48(ent(i), 1'b0);
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("wrap_a_pop%0d", i), rq_if.render_queue_dout, ent(i));
            pop1();
        end
        for (int i = 101; i <= 110; i++) push48(ent(i), 1'b0);
        for (int i = 101; i <= 110; i++) begin
            check($sformatf("wrap_b_pop%0d", i), rq_if.render_queue_dout, ent(i));
            pop1();
        end
        read_reg(2'd3, rv);
        check("wrap_end_status", 48'(rv), 48'h2000);

        // Push and pop together with a partly filled queue.
        for (int i = 201; i <= 203; i++) push48(ent(i), 1'b0);
        push48(ent(204), 1'b1);
        read_reg(2'd3, rv);
        check("mid_pushpop_status", 48'(rv), 48'h0003);
        for (int i = 202; i <= 204; i++) begin
            check($sformatf("mid_pushpop_pop%0d", i), rq_if.render_queue_dout, ent(i));
            pop1();
        end

        // Reset in the middle of a stream discards everything.
        do_reset();
        for (int i = 1; i <= 5; i++) push48(ent(i), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 16'hAAAA);
        do_reset();
        check("midreset_empty", 48'(rq_if.render_queue_empty), 48'(1'b1));
        check("midreset_dout", rq_if.render_queue_dout, DONE);
        read_reg(2'd3, rv);
        check("midreset_status", 48'(rv), 48'h2000);
        read_reg(2'd0, rv);
        check("midreset_staging", 48'(rv), 48'h0);
        push48(ent(77), 1'b0);
        check("midreset_first_push", rq_if.render_queue_dout, ent(77));
        read_reg(2'd3, rv);
        check("midreset_count", 48'(rv), 48'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
